// File: rtl/dcache_writeline_avalon_pkg.sv
// rtl/dcache_writeline_avalon_pkg.sv - shared constants and helpers for the dcache write-line responder
package dcache_writeline_avalon_pkg;

  // FSM encoding
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_BURST = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef logic [1:0] state_t;

  // Cache geometry: one 128-bit line is four 32-bit beats
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] BURST_LEN      = 3'd4;
  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

  // 4:1 word select out of a line; word 0 sits in the low bits
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    logic [WORD_W-1:0] w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dcache_writeline_avalon_if.sv
// rtl/dcache_writeline_avalon_if.sv - Avalon-MM burst write bus between responder and memory
interface dcache_writeline_avalon_if;

  logic [29:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [2:0]  avm_burstcount;
  logic        avm_write;
  logic        avm_waitrequest;

  // Side that issues the write burst
  modport master (
    output avm_address,
    output avm_writedata,
    output avm_byteenable,
    output avm_burstcount,
    output avm_write,
    input  avm_waitrequest
  );

  // Memory side that accepts the burst
  modport slave (
    input  avm_address,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_burstcount,
    input  avm_write,
    output avm_waitrequest
  );

endinterface

// File: rtl/dcache_writeline_avalon.sv
// rtl/dcache_writeline_avalon.sv - writes one dirty 128-bit cache line as a 4-beat Avalon-MM burst
module dcache_writeline_avalon
  import dcache_writeline_avalon_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        writeline_do,
  output logic                        writeline_done,
  input  logic [31:0]                 writeline_address,
  input  logic [127:0]                writeline_line,
  output logic                        busy,
  dcache_writeline_avalon_if.master   avm
);

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [27:0]   addr_q, addr_d;
  logic [127:0]  line_q, line_d;

  // Low address bits select a byte within the line and are meaningless here
  logic          unused_addr_low;
  assign unused_addr_low = ^writeline_address[3:0];

  // State register plus captured request copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 28'd0;
      line_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next state: capture in IDLE, advance one beat per accepted transfer, single DONE cycle
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      STATE_IDLE: begin
        if (writeline_do) begin
          addr_d  = writeline_address[31:4];
          line_d  = writeline_line;
          beat_d  = 2'd0;
          state_d = STATE_BURST;
        end
      end
      STATE_BURST: begin
        // avm_write is always high in BURST, so acceptance is just ~waitrequest
        if (!avm.avm_waitrequest) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = STATE_DONE;
          end
        end
      end
      STATE_DONE: begin
        // Requester still holds do this cycle; it is deliberately not sampled
        state_d = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they hold steady under waitrequest
  always_comb begin
    avm.avm_write      = 1'b0;
    avm.avm_address    = 30'd0;
    avm.avm_writedata  = 32'd0;
    avm.avm_byteenable = 4'd0;
    avm.avm_burstcount = 3'd0;
    writeline_done     = 1'b0;
    busy               = 1'b0;
    case (state_q)
      STATE_BURST: begin
        avm.avm_write      = 1'b1;
        avm.avm_address    = {addr_q, 2'b00};
        avm.avm_writedata  = line_word(line_q, beat_q);
        avm.avm_byteenable = BYTEENABLE_ALL;
        avm.avm_burstcount = BURST_LEN;
        busy               = 1'b1;
      end
      STATE_DONE: begin
        writeline_done = 1'b1;
        busy           = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_writeline_avalon.sv
// tb/tb_dcache_writeline_avalon.sv - randomized self-checking bench for dcache_writeline_avalon
module tb_dcache_writeline_avalon;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         writeline_do = 1'b0;
  logic         writeline_done;
  logic [31:0]  writeline_address = 32'd0;
  logic [127:0] writeline_line = 128'd0;
  logic         busy;

  dcache_writeline_avalon_if avm_if();

  dcache_writeline_avalon dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .writeline_do      (writeline_do),
    .writeline_done    (writeline_done),
    .writeline_address (writeline_address),
    .writeline_line    (writeline_line),
    .busy              (busy),
    .avm               (avm_if)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations collected by run_line
  logic [31:0] obs_data [8];
  logic [29:0] obs_addr [8];
  int          obs_beats;
  int          obs_done_cycle;
  int          obs_unstable;
  int          obs_ctrl_bad;
  int          obs_idle_bad;
  bit          stall [64];

  // Reference model: word i of a line, word address of a line, and completion cycle
  function automatic logic [31:0] model_word(input logic [127:0] l, input int i);
    return l[i*32 +: 32];
  endfunction

  function automatic logic [29:0] model_addr(input logic [31:0] a);
    logic [31:0] t;
    t = (a / 16) * 4;
    return t[29:0];
  endfunction

  function automatic int model_done_cycle();
    int acc;
    acc = 0;
    for (int c = 1; c < 64; c++) begin
      if (!stall[c]) acc++;
      if (acc == 4) return c + 1;
    end
    return -1;
  endfunction

  function automatic void clear_stall();
    for (int i = 0; i < 64; i++) stall[i] = 1'b0;
  endfunction

  // Drives one request (do held through done) and records what the bus carried
  task automatic run_line(input logic [31:0] a, input logic [127:0] l, input bit scramble);
    bit          prev_stall;
    logic [29:0] pa;
    logic [31:0] pd;
    logic [3:0]  pbe;
    logic [2:0]  pbc;
    logic        pw;
    obs_beats = 0; obs_done_cycle = -1; obs_unstable = 0; obs_ctrl_bad = 0; obs_idle_bad = 0;
    prev_stall = 1'b0; pa = '0; pd = '0; pbe = '0; pbc = '0; pw = 1'b0;
    @(negedge clk);
    writeline_do = 1'b1;
    writeline_address = a;
    writeline_line = l;
    avm_if.avm_waitrequest = 1'b0;
    #1;
    if (busy !== 1'b0 || avm_if.avm_write !== 1'b0 || writeline_done !== 1'b0) obs_idle_bad++;
    for (int c = 1; c < 64 && obs_done_cycle < 0; c++) begin
      @(negedge clk);
      avm_if.avm_waitrequest = stall[c];
      if (scramble) begin
        writeline_line = {$urandom, $urandom, $urandom, $urandom};
        writeline_address = $urandom;
      end
      #1;
      if (prev_stall && {avm_if.avm_address, avm_if.avm_writedata, avm_if.avm_byteenable,
                         avm_if.avm_burstcount, avm_if.avm_write} !== {pa, pd, pbe, pbc, pw})
        obs_unstable++;
      if (writeline_done === 1'b1) begin
        obs_done_cycle = c;
        if (avm_if.avm_write !== 1'b0 || busy !== 1'b1) obs_ctrl_bad++;
      end else begin
        if (avm_if.avm_write !== 1'b1 || busy !== 1'b1 || avm_if.avm_burstcount !== 3'd4 ||
            avm_if.avm_byteenable !== 4'hF) obs_ctrl_bad++;
        if (avm_if.avm_write === 1'b1 && !stall[c]) begin
          if (obs_beats < 8) begin
            obs_data[obs_beats] = avm_if.avm_writedata;
            obs_addr[obs_beats] = avm_if.avm_address;
          end
          obs_beats++;
        end
      end
      prev_stall = (avm_if.avm_write === 1'b1) && stall[c];
      pa = avm_if.avm_address; pd = avm_if.avm_writedata; pbe = avm_if.avm_byteenable;
      pbc = avm_if.avm_burstcount; pw = avm_if.avm_write;
    end
    avm_if.avm_waitrequest = 1'b0;
  endtask

  task automatic release_do();
    @(negedge clk);
    writeline_do = 1'b0;
  endtask

  task automatic test_reset();
    avm_if.avm_waitrequest = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata, avm_if.avm_byteenable,
         avm_if.avm_burstcount, writeline_done} !== '0)
      $display("FAIL reset_outputs: write=%b addr=%h data=%h be=%h bc=%h done=%b required all 0",
               avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata,
               avm_if.avm_byteenable, avm_if.avm_burstcount, writeline_done);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_line();
    logic [127:0] l;
    l = 128'h44444444_33333333_22222222_11111111;
    clear_stall();
    run_line(32'h0001_2340, l, 1'b0);
    release_do();
    total_cnt++;
    if (obs_beats !== 4) $display("FAIL single_beats: got %0d required 4", obs_beats);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (obs_data[i] !== model_word(l, i))
        $display("FAIL single_data[%0d]: got %h required %h", i, obs_data[i], model_word(l, i));
      else pass_cnt++;
      total_cnt++;
      if (obs_addr[i] !== 30'h48D0)
        $display("FAIL single_addr[%0d]: got %h required 48d0", i, obs_addr[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done_cycle !== 5) $display("FAIL single_done_cycle: got %0d required 5", obs_done_cycle);
    else pass_cnt++;
    total_cnt++;
    if (obs_ctrl_bad !== 0 || obs_idle_bad !== 0)
      $display("FAIL single_ctrl: bad=%0d idle_bad=%0d required 0", obs_ctrl_bad, obs_idle_bad);
    else pass_cnt++;
  endtask

  task automatic test_stalls();
    logic [127:0] l;
    l = {$urandom, $urandom, $urandom, $urandom};
    clear_stall();
    stall[1] = 1; stall[2] = 1; stall[3] = 1; stall[6] = 1; stall[7] = 1;
    run_line(32'h8000_0010, l, 1'b0);
    release_do();
    total_cnt++;
    if (obs_done_cycle !== 10 || model_done_cycle() !== 10)
      $display("FAIL stall_done_cycle: got %0d required 10", obs_done_cycle);
    else pass_cnt++;
    total_cnt++;
    if (obs_beats !== 4) $display("FAIL stall_beats: got %0d required 4", obs_beats);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (obs_data[i] !== model_word(l, i))
        $display("FAIL stall_data[%0d]: got %h required %h", i, obs_data[i], model_word(l, i));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_unstable !== 0) $display("FAIL stall_stable: got %0d changes required 0", obs_unstable);
    else pass_cnt++;
  endtask

  task automatic test_addr_low_bits();
    logic [127:0] l;
    l = {$urandom, $urandom, $urandom, $urandom};
    clear_stall();
    run_line(32'hFFFF_FFFF, l, 1'b0);
    release_do();
    total_cnt++;
    if (obs_addr[0] !== 30'h3FFF_FFFC || obs_addr[3] !== 30'h3FFF_FFFC)
      $display("FAIL addr_low_bits: got %h/%h required 3ffffffc", obs_addr[0], obs_addr[3]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] l1, l2;
    int dones;
    l1 = {$urandom, $urandom, $urandom, $urandom};
    l2 = {$urandom, $urandom, $urandom, $urandom};
    clear_stall();
    dones = 0;
    run_line(32'h0000_1000, l1, 1'b0);
    if (obs_done_cycle > 0) dones++;
    run_line(32'h0000_2000, l2, 1'b0);
    if (obs_done_cycle > 0) dones++;
    total_cnt++;
    if (obs_idle_bad !== 0 || obs_done_cycle !== 5)
      $display("FAIL b2b_second_timing: idle_bad=%0d done=%0d required 0/5", obs_idle_bad, obs_done_cycle);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (obs_data[i] !== model_word(l2, i) || obs_addr[i] !== model_addr(32'h0000_2000))
        $display("FAIL b2b_data[%0d]: got %h@%h required %h@%h", i, obs_data[i], obs_addr[i],
                 model_word(l2, i), model_addr(32'h0000_2000));
      else pass_cnt++;
    end
    writeline_do = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (writeline_done === 1'b1) dones++;
    end
    total_cnt++;
    if (dones !== 2) $display("FAIL b2b_done_pulses: got %0d required 2", dones);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    logic [127:0] l, l2;
    l = {$urandom, $urandom, $urandom, $urandom};
    l2 = {$urandom, $urandom, $urandom, $urandom};
    clear_stall();
    @(negedge clk);
    writeline_do = 1'b1; writeline_address = 32'h0000_4000; writeline_line = l;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (avm_if.avm_writedata !== model_word(l, 2))
      $display("FAIL rstmid_beat2: got %h required %h", avm_if.avm_writedata, model_word(l, 2));
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (avm_if.avm_write !== 1'b0 || busy !== 1'b0 || avm_if.avm_address !== 30'd0 ||
        avm_if.avm_writedata !== 32'd0)
      $display("FAIL rstmid_outputs: write=%b busy=%b addr=%h data=%h required 0",
               avm_if.avm_write, busy, avm_if.avm_address, avm_if.avm_writedata);
    else pass_cnt++;
    writeline_do = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_line(32'h0000_5000, l2, 1'b0);
    release_do();
    total_cnt++;
    if (obs_beats !== 4 || obs_done_cycle !== 5)
      $display("FAIL rstmid_rerun: beats=%0d done=%0d required 4/5", obs_beats, obs_done_cycle);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (obs_data[i] !== model_word(l2, i))
        $display("FAIL rstmid_data[%0d]: got %h required %h", i, obs_data[i], model_word(l2, i));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [127:0] l;
    logic [31:0]  a;
    bit           scr;
    for (int n = 0; n < 10; n++) begin
      l = {$urandom, $urandom, $urandom, $urandom};
      a = $urandom;
      scr = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      clear_stall();
      for (int c = 1; c < 20; c++) stall[c] = ($urandom_range(0, 9) < 3);
      run_line(a, l, scr);
      total_cnt++;
      if (obs_done_cycle !== model_done_cycle() || obs_beats !== 4)
        $display("FAIL rand%0d_timing: done=%0d beats=%0d required %0d/4", n, obs_done_cycle,
                 obs_beats, model_done_cycle());
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if (obs_data[i] !== model_word(l, i) || obs_addr[i] !== model_addr(a))
          $display("FAIL rand%0d_beat%0d: got %h@%h required %h@%h", n, i, obs_data[i],
                   obs_addr[i], model_word(l, i), model_addr(a));
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_unstable !== 0 || obs_ctrl_bad !== 0 || obs_idle_bad !== 0)
        $display("FAIL rand%0d_ctrl: unstable=%0d ctrl=%0d idle=%0d required 0", n,
                 obs_unstable, obs_ctrl_bad, obs_idle_bad);
      else pass_cnt++;
      release_do();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    avm_if.avm_waitrequest = 1'b0;
    clear_stall();
    test_reset();
    test_single_line();
    test_stalls();
    test_addr_low_bits();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_writeline_avalon.md
Name: dcache_writeline_avalon

Overview:
- Responder for the data-cache write-line request interface (writeline_do/done/address/line).
- Issued by the dcache control path during WBINVD flush and dirty-line eviction.
- Accepts one 128-bit dirty line and writes it to memory as a single 4-beat Avalon-MM write burst of 32-bit words, then pulses writeline_done.
- Sits between dcache control and the Avalon memory master port.

Parameters:
None. Line width 128, beat width 32 and burst length 4 are fixed by the cache geometry.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
writeline_do  input  1  request; held high with address/line stable until writeline_done
writeline_done  output  1  one-cycle pulse: line fully accepted by memory
writeline_address  input  32  line address; bits [3:0] ignored (line-aligned)
writeline_line  input  128  line data; word 0 = [31:0]
avm_address  output  30  word address [31:2]; constant for whole burst
avm_writedata  output  32  current beat data
avm_byteenable  output  4  always 4'hF while writing
avm_burstcount  output  3  3'd4 while writing
avm_write  output  1  write strobe
avm_waitrequest  input  1  slave stall
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, beat=0, writeline_done=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, avm_burstcount=0, busy=0, line buffer=0.
- States: IDLE, BURST, DONE.
- IDLE:
  - On writeline_do=1, capture writeline_address[31:4] and writeline_line into registers, set beat=0, go to BURST.
  - writeline_do=0: stay in IDLE.
- BURST:
  - avm_write=1, avm_address={addr[31:4],2'b00}, avm_burstcount=4, avm_byteenable=4'hF.
  - avm_writedata=buffer word[beat]: word 0 = bits [31:0], word 3 = bits [127:96].
  - A beat is accepted when avm_write & ~avm_waitrequest; on acceptance beat increments.
  - While avm_waitrequest=1, all avm_* outputs hold stable, including before the first beat is accepted.
  - Acceptance of beat 3 leads to DONE; beat wraps to 0.
- DONE:
  - writeline_done=1 for exactly this cycle; avm_write=0.
  - writeline_do is ignored in DONE (the requester still holds it this cycle).
  - Next state is IDLE unconditionally.
- Back-to-back requests: the requester may present the next line the cycle after done. IDLE then captures it with no further bubble.
- Latency with no waitrequest: do sampled at cycle 0, beats at cycles 1-4, done at cycle 5. Each waitrequest cycle adds one cycle.
- Captured copy: once captured, changes on writeline_address/line are not observed until the next IDLE capture.
- Requester drops do mid-burst: protocol violation, but the burst still completes and done still pulses.
- Reset mid-burst: asynchronous return to IDLE with all outputs at reset values; the partial burst is abandoned.
- busy=1 in BURST and DONE.
- Widths: beat is 2 bits; word select uses beat directly; no arithmetic beyond the beat increment.

Decomposition:
- Shared package holds:
  - state localparams STATE_IDLE=2'd0, STATE_BURST=2'd1, STATE_DONE=2'd2;
  - BURST_LEN=3'd4;
  - BYTEENABLE_ALL=4'hF.
- No sub-module needed. The beat-data mux is a 4:1 select inside the block.

Test Plan:
- Single line, no stall: do with addr=0x0001_2340, line=0x44444444_33333333_22222222_11111111 -> beats at cycles 1-4 with data 0x11111111, 0x22222222, 0x33333333, 0x44444444; avm_address=0x48D0 on every beat; burstcount=4; done=1 only at cycle 5.
- Waitrequest stalls: waitrequest high 3 cycles before beat 0 and 2 cycles during beat 2 -> outputs stable while stalled, 4 beats total, done at cycle 10, never a duplicated or skipped word.
- Address low bits ignored: addr=0xFFFF_FFFF -> avm_address=0x3FFF_FFFC.
- Back-to-back: requester holds do through done and presents a new line the next cycle -> second burst starts one cycle after IDLE capture; first line not rewritten; exactly 2 done pulses.
- Reset mid-burst: assert rst_n=0 after beat 1 is accepted -> avm_write=0 and busy=0 immediately; a new request after reset produces a full 4-beat burst starting at word 0.
- Stable-capture check: change writeline_line during BURST -> beats carry the originally captured data.
